// File: rtl/uart_tx.sv
// uart_tx: transmit-only 8N1 UART serializer.
// Accepts a byte on a single-cycle start strobe, then shifts out one start
// bit, eight data bits LSB first and one stop bit. Each bit lasts
// CLKS_PER_BIT system clocks. tx and tx_busy come straight from flops.
// CLOCK_FREQ / BAUD_RATE must be at least 2.
module uart_tx #(
   parameter int CLOCK_FREQ = 12000000,
   parameter int BAUD_RATE  = 115200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx,
   output logic       tx_busy
);

   localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [2:0]       bit_q,   bit_d;
   logic [7:0]       shreg_q, shreg_d;
   logic             tx_q,    tx_d;
   logic             busy_q,  busy_d;

   logic             cnt_done;

   assign cnt_done = (cnt_q == CNT_LAST);

   // State and datapath registers; reset aborts any frame and idles the line high.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
      end
   end

   // Next-state logic: bit timing, data shifting and next line level.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      tx_d    = tx_q;
      busy_d  = busy_q;

      case (state_q)
         IDLE: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (tx_start) begin
               // The byte is captured here only, so later tx_data changes
               // cannot disturb the frame in flight.
               shreg_d = tx_data;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
               cnt_d   = '0;
               state_d = START;
            end
         end

         START: begin
            if (cnt_done) begin
               cnt_d   = '0;
               bit_d   = '0;
               tx_d    = shreg_q[0];
               state_d = DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         DATA: begin
            if (cnt_done) begin
               cnt_d = '0;
               if (bit_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = STOP;
               end else begin
                  // Bit 0 of the shift register always holds the bit on the line.
                  bit_d   = bit_q + 3'd1;
                  shreg_d = {1'b0, shreg_q[7:1]};
                  tx_d    = shreg_q[1];
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         STOP: begin
            if (cnt_done) begin
               cnt_d   = '0;
               tx_d    = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign tx      = tx_q;
   assign tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx at default parameters.
// Accepted bytes are queued; a negedge monitor rebuilds each frame's
// expected waveform from the queued byte and checks it cycle by cycle.
module tb_uart_tx;

   localparam int CPB     = 104;
   localparam int FRAME_C = 10 * CPB;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx;
   logic       tx_busy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] sb[$];

   // monitor state
   bit         in_frame   = 1'b0;
   bit         abort_flag = 1'b0;
   logic [7:0] cur_byte   = 8'h00;
   int         k          = 0;
   int         wave_errs  = 0;
   int         idle_errs  = 0;
   int         gap        = 0;
   int         last_gap   = -1;
   int         frames_ok  = 0;

   uart_tx #(
      .CLOCK_FREQ(12000000),
      .BAUD_RATE (115200)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .tx_start(tx_start),
      .tx_data (tx_data),
      .tx      (tx),
      .tx_busy (tx_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Expected line level at cycle kk of a frame carrying byte d.
   function automatic logic exp_level(input logic [7:0] d, input int kk);
      int b;
      b = kk / CPB;
      if (b == 0) return 1'b0;
      if (b <= 8) return d[b-1];
      return 1'b1;
   endfunction

   // Frame monitor: compares the line against the scoreboard byte.
   always @(negedge clk) begin
      if (!in_frame && tx_busy) begin
         in_frame  = 1'b1;
         k         = 0;
         wave_errs = 0;
         last_gap  = gap;
         gap       = 0;
         if (sb.size() == 0) begin
            check("unexpected_frame", 1, 0);
            cur_byte = 8'h00;
         end else begin
            cur_byte = sb.pop_front();
         end
      end
      if (in_frame) begin
         if (tx_busy) begin
            if (tx !== exp_level(cur_byte, k)) wave_errs++;
            k++;
         end else begin
            in_frame = 1'b0;
            if (abort_flag) begin
               abort_flag = 1'b0;
            end else begin
               check($sformatf("frame_len_%02h", cur_byte), k, FRAME_C);
               check($sformatf("wave_errs_%02h", cur_byte), wave_errs, 0);
               frames_ok++;
            end
         end
      end
      if (!in_frame) begin
         gap++;
         if (tx !== 1'b1) idle_errs++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_idle(input int budget);
      int c;
      c = 0;
      while (tx_busy && c < budget) begin
         tick();
         c++;
      end
      if (tx_busy) check("timeout_idle", 1, 0);
   endtask

   task automatic wait_busy(input int budget);
      int c;
      c = 0;
      while (!tx_busy && c < budget) begin
         tick();
         c++;
      end
      if (!tx_busy) check("timeout_busy", 1, 0);
   endtask

   task automatic send(input logic [7:0] d);
      tx_data  = d;
      sb.push_back(d);
      tx_start = 1'b1;
      tick();
      tx_start = 1'b0;
   endtask

   initial begin
      rst_n    = 1'b0;
      tx_start = 1'b0;
      tx_data  = 8'h00;
      ticks(3);
      check("rst_tx", int'(tx), 1);
      check("rst_busy", int'(tx_busy), 0);
      rst_n = 1'b1;

      // Idle line
      ticks(250);
      check("idle_busy", int'(tx_busy), 0);
      check("idle_tx", int'(tx), 1);

      // First frame; busy and start bit appear on the same edge
      send(8'hAA);
      check("start_tx_low", int'(tx), 0);
      check("start_busy", int'(tx_busy), 1);
      wait_idle(2000);
      ticks(250);

      // tx_data change mid-frame must not alter the waveform
      send(8'hBB);
      ticks(300);
      tx_data = 8'h00;
      wait_idle(2000);
      ticks(5);

      // Starts during a busy frame are ignored
      send(8'h3C);
      ticks(98);
      tx_start = 1'b1; tick(); tx_start = 1'b0;
      ticks(399);
      tx_start = 1'b1; tick(); tx_start = 1'b0;
      wait_idle(2000);
      ticks(20);
      check("no_requeue_busy", int'(tx_busy), 0);

      // Reset in the middle of data bit 3
      send(8'hC3);
      ticks(CPB * 4 + 50 - 1);
      abort_flag = 1'b1;
      rst_n = 1'b0;
      tick();
      check("abort_tx", int'(tx), 1);
      check("abort_busy", int'(tx_busy), 0);
      rst_n = 1'b1;
      ticks(10);
      send(8'h96);
      wait_idle(2000);
      ticks(10);

      // tx_start held across two frames
      tx_data  = 8'h55;
      sb.push_back(8'h55);
      sb.push_back(8'h55);
      tx_start = 1'b1;
      tick();
      wait_idle(2000);
      check("b2b_gap_busy", int'(tx_busy), 0);
      check("b2b_gap_tx", int'(tx), 1);
      wait_busy(10);
      ticks(5);
      tx_start = 1'b0;
      check("b2b_gap_len", last_gap, 1);
      wait_idle(2000);
      ticks(10);

      check("sb_empty", sb.size(), 0);
      check("frames_done", frames_ok, 6);
      check("idle_errs", idle_errs, 0);
      check("final_busy", int'(tx_busy), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
